// File: rtl/addition_sweep_checker.sv
// Exhaustive sweep harness for a combinational WIDTH-bit adder: drives every
// operand pair, samples the result after SETTLE extra cycles, and tallies mismatches.
module addition_sweep_checker #(
   parameter int WIDTH        = 8,
   parameter int SETTLE       = 0,
   parameter bit STOP_ON_FAIL = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [WIDTH-1:0]     op1,
   output logic [WIDTH-1:0]     op2,
   input  logic [WIDTH-1:0]     result,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     mismatch_count,
   output logic                 first_fail_valid,
   output logic [WIDTH-1:0]     first_fail_op1,
   output logic [WIDTH-1:0]     first_fail_op2,
   output logic [WIDTH-1:0]     first_fail_result
);

   localparam int IW = 2 * WIDTH;
   localparam int CW = 2 * WIDTH + 1;
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE);
   localparam logic [IW-1:0] IDX_LAST    = '1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t          state, state_next;
   logic [IW-1:0]   idx, idx_next;
   logic [3:0]      cnt, cnt_next;
   logic [CW-1:0]   count_next;
   logic            done_next, pass_next, ffv_next;
   logic [WIDTH-1:0] ff1_next, ff2_next, ffr_next;
   logic [WIDTH-1:0] expected;
   logic            miss;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state             <= IDLE;
         idx               <= '0;
         cnt               <= '0;
         mismatch_count    <= '0;
         done              <= 1'b0;
         pass              <= 1'b0;
         first_fail_valid  <= 1'b0;
         first_fail_op1    <= '0;
         first_fail_op2    <= '0;
         first_fail_result <= '0;
      end else begin
         state             <= state_next;
         idx               <= idx_next;
         cnt               <= cnt_next;
         mismatch_count    <= count_next;
         done              <= done_next;
         pass              <= pass_next;
         first_fail_valid  <= ffv_next;
         first_fail_op1    <= ff1_next;
         first_fail_op2    <= ff2_next;
         first_fail_result <= ffr_next;
      end
   end

   // Abort outranks the compare; the final vector and a stop-on-fail miss both hold idx.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      cnt_next   = cnt;
      count_next = mismatch_count;
      done_next  = 1'b0;
      pass_next  = pass;
      ffv_next   = first_fail_valid;
      ff1_next   = first_fail_op1;
      ff2_next   = first_fail_op2;
      ffr_next   = first_fail_result;
      expected   = idx[IW-1:WIDTH] + idx[WIDTH-1:0];
      miss       = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = RUN;
               idx_next   = '0;
               cnt_next   = '0;
               count_next = '0;
               pass_next  = 1'b0;
               ffv_next   = 1'b0;
               ff1_next   = '0;
               ff2_next   = '0;
               ffr_next   = '0;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
               pass_next  = 1'b0;
            end else if (cnt == SETTLE_LAST) begin
               miss     = (result != expected);
               cnt_next = '0;
               if (miss) begin
                  count_next = mismatch_count + CW'(1);
                  if (!first_fail_valid) begin
                     ffv_next = 1'b1;
                     ff1_next = idx[IW-1:WIDTH];
                     ff2_next = idx[WIDTH-1:0];
                     ffr_next = result;
                  end
               end
               if (miss && STOP_ON_FAIL) begin
                  state_next = DONE;
                  done_next  = 1'b1;
                  pass_next  = 1'b0;
               end else if (idx == IDX_LAST) begin
                  state_next = DONE;
                  done_next  = 1'b1;
                  pass_next  = (count_next == '0);
               end else begin
                  idx_next = idx + IW'(1);
               end
            end else begin
               cnt_next = cnt + 4'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign op1  = idx[IW-1:WIDTH];
   assign op2  = idx[WIDTH-1:0];
   assign busy = (state == RUN);

endmodule

// File: tb/tb_addition_sweep_checker.sv
// Directed bench for addition_sweep_checker: one 8-bit ideal sweep plus 4-bit
// instances exercising injected faults, settle time, stop-on-fail, abort and reset.
module tb_addition_sweep_checker;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic abort;
   int   sel;
   int   mode;
   int   checks = 0;
   int   errors = 0;
   int   cycles;

   always #5 clk = ~clk;

   // Adder under test: mode 0 ideal, 1 wrong only at 3+5, 2 bit0 stuck at 0
   function automatic logic [7:0] faulty_sum(input logic [7:0] a, input logic [7:0] b, input int m);
      logic [7:0] s;
      s = a + b;
      if (m == 1 && a == 8'h03 && b == 8'h05) s = 8'h09;
      if (m == 2) s[0] = 1'b0;
      return s;
   endfunction

   logic [7:0]  op1_8, op2_8, res_8, ff1_8, ff2_8, ffr_8;
   logic [16:0] cnt_8;
   logic        busy_8, done_8, pass_8, ffv_8;

   logic [3:0]  op1_a, op2_a, res_a, ff1_a, ff2_a, ffr_a;
   logic [3:0]  op1_b, op2_b, res_b, ff1_b, ff2_b, ffr_b;
   logic [3:0]  op1_c, op2_c, res_c, ff1_c, ff2_c, ffr_c;
   logic [8:0]  cnt_a, cnt_b, cnt_c;
   logic        busy_a, done_a, pass_a, ffv_a;
   logic        busy_b, done_b, pass_b, ffv_b;
   logic        busy_c, done_c, pass_c, ffv_c;
   logic [7:0]  sum_a, sum_b, sum_c;

   assign res_8 = faulty_sum(op1_8, op2_8, mode);
   assign sum_a = faulty_sum({4'h0, op1_a}, {4'h0, op2_a}, mode);
   assign sum_b = faulty_sum({4'h0, op1_b}, {4'h0, op2_b}, mode);
   assign sum_c = faulty_sum({4'h0, op1_c}, {4'h0, op2_c}, mode);
   assign res_a = sum_a[3:0];
   assign res_b = sum_b[3:0];
   assign res_c = sum_c[3:0];

   addition_sweep_checker #(.WIDTH(8), .SETTLE(0), .STOP_ON_FAIL(1'b0)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .abort(1'b0),
      .op1(op1_8), .op2(op2_8), .result(res_8), .busy(busy_8), .done(done_8),
      .pass(pass_8), .mismatch_count(cnt_8), .first_fail_valid(ffv_8),
      .first_fail_op1(ff1_8), .first_fail_op2(ff2_8), .first_fail_result(ffr_8));

   addition_sweep_checker #(.WIDTH(4), .SETTLE(0), .STOP_ON_FAIL(1'b0)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .abort(abort),
      .op1(op1_a), .op2(op2_a), .result(res_a), .busy(busy_a), .done(done_a),
      .pass(pass_a), .mismatch_count(cnt_a), .first_fail_valid(ffv_a),
      .first_fail_op1(ff1_a), .first_fail_op2(ff2_a), .first_fail_result(ffr_a));

   addition_sweep_checker #(.WIDTH(4), .SETTLE(2), .STOP_ON_FAIL(1'b0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .abort(1'b0),
      .op1(op1_b), .op2(op2_b), .result(res_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .mismatch_count(cnt_b), .first_fail_valid(ffv_b),
      .first_fail_op1(ff1_b), .first_fail_op2(ff2_b), .first_fail_result(ffr_b));

   addition_sweep_checker #(.WIDTH(4), .SETTLE(0), .STOP_ON_FAIL(1'b1)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .start(start && sel == 3), .abort(1'b0),
      .op1(op1_c), .op2(op2_c), .result(res_c), .busy(busy_c), .done(done_c),
      .pass(pass_c), .mismatch_count(cnt_c), .first_fail_valid(ffv_c),
      .first_fail_op1(ff1_c), .first_fail_op2(ff2_c), .first_fail_result(ffr_c));

   logic [31:0] m_busy, m_done, m_pass, m_cnt, m_ffv, m_ff1, m_ff2, m_ffr, m_op1, m_op2;

   // Route the currently selected instance onto one set of observation signals
   always_comb begin
      m_busy = 0; m_done = 0; m_pass = 0; m_cnt = 0; m_ffv = 0;
      m_ff1 = 0; m_ff2 = 0; m_ffr = 0; m_op1 = 0; m_op2 = 0;
      case (sel)
         0: begin
            m_busy = 32'(busy_8); m_done = 32'(done_8); m_pass = 32'(pass_8);
            m_cnt = 32'(cnt_8); m_ffv = 32'(ffv_8); m_ff1 = 32'(ff1_8);
            m_ff2 = 32'(ff2_8); m_ffr = 32'(ffr_8); m_op1 = 32'(op1_8); m_op2 = 32'(op2_8);
         end
         1: begin
            m_busy = 32'(busy_a); m_done = 32'(done_a); m_pass = 32'(pass_a);
            m_cnt = 32'(cnt_a); m_ffv = 32'(ffv_a); m_ff1 = 32'(ff1_a);
            m_ff2 = 32'(ff2_a); m_ffr = 32'(ffr_a); m_op1 = 32'(op1_a); m_op2 = 32'(op2_a);
         end
         2: begin
            m_busy = 32'(busy_b); m_done = 32'(done_b); m_pass = 32'(pass_b);
            m_cnt = 32'(cnt_b); m_ffv = 32'(ffv_b); m_ff1 = 32'(ff1_b);
            m_ff2 = 32'(ff2_b); m_ffr = 32'(ffr_b); m_op1 = 32'(op1_b); m_op2 = 32'(op2_b);
         end
         default: begin
            m_busy = 32'(busy_c); m_done = 32'(done_c); m_pass = 32'(pass_c);
            m_cnt = 32'(cnt_c); m_ffv = 32'(ffv_c); m_ff1 = 32'(ff1_c);
            m_ff2 = 32'(ff2_c); m_ffr = 32'(ffr_c); m_op1 = 32'(op1_c); m_op2 = 32'(op2_c);
         end
      endcase
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Pulse start for one edge on the selected instance and confirm the sweep began at vector 0
   task automatic applyStimulus(input int which, input int fault);
      @(negedge clk);
      sel   = which;
      mode  = fault;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("start_busy", m_busy, 1);
      checkOutput("start_op1", m_op1, 0);
      checkOutput("start_op2", m_op2, 0);
      checkOutput("start_count", m_cnt, 0);
      checkOutput("start_ffv", m_ffv, 0);
   endtask

   task automatic waitDone(input int limit, output int n);
      n = 0;
      while (m_done !== 32'd1 && n < limit) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic checkFirstFail(input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] r);
      checkOutput("ff_valid", m_ffv, 1);
      checkOutput("ff_op1", m_ff1, o1);
      checkOutput("ff_op2", m_ff2, o2);
      checkOutput("ff_result", m_ffr, r);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      sel   = 1;
      mode  = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", m_busy, 0);
      checkOutput("rst_done", m_done, 0);
      checkOutput("rst_pass", m_pass, 0);
      checkOutput("rst_op1", m_op1, 0);
      checkOutput("rst_op2", m_op2, 0);
      checkOutput("rst_count", m_cnt, 0);
      checkOutput("rst_ffv", m_ffv, 0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] 8-bit ideal sweep");
      applyStimulus(0, 0);
      waitDone(70000, cycles);
      checkOutput("w8_cycles", cycles, 65536);
      checkOutput("w8_busy", m_busy, 0);
      checkOutput("w8_pass", m_pass, 1);
      checkOutput("w8_count", m_cnt, 0);
      checkOutput("w8_ffv", m_ffv, 0);
      checkOutput("w8_op1", m_op1, 32'hFF);
      checkOutput("w8_op2", m_op2, 32'hFF);
      @(posedge clk);
      #1;
      checkOutput("w8_done_pulse", m_done, 0);
      checkOutput("w8_pass_held", m_pass, 1);

      $display("[TB] single wrong vector 3+5");
      applyStimulus(1, 1);
      waitDone(600, cycles);
      checkOutput("one_cycles", cycles, 256);
      checkOutput("one_count", m_cnt, 1);
      checkOutput("one_pass", m_pass, 0);
      checkFirstFail(3, 5, 9);
      checkOutput("one_op1", m_op1, 32'hF);
      checkOutput("one_op2", m_op2, 32'hF);

      $display("[TB] bit0 stuck, settle 0");
      applyStimulus(1, 2);
      waitDone(600, cycles);
      checkOutput("stuck_cycles", cycles, 256);
      checkOutput("stuck_count", m_cnt, 128);
      checkOutput("stuck_pass", m_pass, 0);
      checkFirstFail(0, 1, 0);

      $display("[TB] bit0 stuck, settle 2");
      applyStimulus(2, 2);
      waitDone(1600, cycles);
      checkOutput("settle_cycles", cycles, 768);
      checkOutput("settle_count", m_cnt, 128);
      checkFirstFail(0, 1, 0);

      $display("[TB] bit0 stuck, stop on fail");
      applyStimulus(3, 2);
      waitDone(600, cycles);
      checkOutput("sof_cycles", cycles, 2);
      checkOutput("sof_count", m_cnt, 1);
      checkOutput("sof_pass", m_pass, 0);
      checkOutput("sof_busy", m_busy, 0);
      checkOutput("sof_op1", m_op1, 0);
      checkOutput("sof_op2", m_op2, 1);
      checkFirstFail(0, 1, 0);

      $display("[TB] abort after 100 cycles");
      applyStimulus(1, 2);
      repeat (99) @(posedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      checkOutput("abort_busy", m_busy, 0);
      checkOutput("abort_done", m_done, 0);
      checkOutput("abort_pass", m_pass, 0);
      checkOutput("abort_op1", m_op1, 6);
      checkOutput("abort_op2", m_op2, 3);
      checkOutput("abort_count", m_cnt, 49);
      checkFirstFail(0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("abort_no_done", m_done, 0);
      end
      checkOutput("abort_count_frozen", m_cnt, 49);
      applyStimulus(1, 0);
      waitDone(600, cycles);
      checkOutput("restart_cycles", cycles, 256);
      checkOutput("restart_count", m_cnt, 0);
      checkOutput("restart_pass", m_pass, 1);
      checkOutput("restart_ffv", m_ffv, 0);

      $display("[TB] reset mid-sweep");
      applyStimulus(1, 2);
      repeat (50) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("mrst_busy", m_busy, 0);
      checkOutput("mrst_done", m_done, 0);
      checkOutput("mrst_pass", m_pass, 0);
      checkOutput("mrst_op1", m_op1, 0);
      checkOutput("mrst_op2", m_op2, 0);
      checkOutput("mrst_count", m_cnt, 0);
      checkOutput("mrst_ffv", m_ffv, 0);
      checkOutput("mrst_ffr", m_ffr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         checkOutput("mrst_no_done", m_done, 0);
      end
      applyStimulus(1, 2);
      waitDone(600, cycles);
      checkOutput("fresh_cycles", cycles, 256);
      checkOutput("fresh_count", m_cnt, 128);
      checkFirstFail(0, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/addition_sweep_checker.md
# addition_sweep_checker

Exhaustive sequential test harness for the combinational 8-bit adder netlists produced by the optimization flow. It drives every operand pair onto the adder's `op1`/`op2` inputs and samples the adder's `result` after a programmable settle time. Each sample is compared against a golden modular sum. The block reports a mismatch count and the first failing vector, so each optimized netlist can be signed off in simulation or on an FPGA.

## Interface
Parameters:
- `WIDTH`, 8: operand/result width; sweep covers 2^(2*WIDTH) vectors.
- `SETTLE`, 0: extra cycles between operand change and result sample; legal range 0..15.
- `STOP_ON_FAIL`, 0: 1 ends the sweep at the first mismatch.

Ports:
- `clk`, input, 1: single clock; all state changes on rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `start`, input, 1: begin a sweep (sampled in IDLE/DONE only).
- `abort`, input, 1: terminate a running sweep.
- `op1`, output, WIDTH: operand 1 to the adder (registered).
- `op2`, output, WIDTH: operand 2 to the adder (registered).
- `result`, input, WIDTH: adder output, combinational from `op1`/`op2`.
- `busy`, output, 1: high while sweep running.
- `done`, output, 1: one-cycle pulse at normal or stop-on-fail completion.
- `pass`, output, 1: high after a completed sweep with zero mismatches; held until next `start`.
- `mismatch_count`, output, 2*WIDTH+1: mismatches in current/last sweep.
- `first_fail_valid`, output, 1: first-fail registers hold a vector.
- `first_fail_op1`, output, WIDTH: op1 of first mismatch.
- `first_fail_op2`, output, WIDTH: op2 of first mismatch.
- `first_fail_result`, output, WIDTH: `result` value captured at first mismatch.

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE. All outputs are 0, including `op1`, `op2`, counts and first-fail fields.
- Vector index `idx` (2*WIDTH bits) = {op1, op2`}`; `op2` is the low half, so it increments fastest. The sweep runs from 0 to all-ones.
- Golden value: expected = (op1 + op2) mod 2^WIDTH; the carry is discarded.
- IDLE/DONE with `start`=1 causes these actions:
  - clear counts, first-fail fields and `pass`;
  - set `idx`=0;
  - enter RUN with settle counter 0.
- RUN behaviour:
  - The settle counter counts 0..SETTLE.
  - When the counter reaches SETTLE, compare `result` to expected.
  - On mismatch, increment `mismatch_count`. If `first_fail_valid`=0, also capture op1/op2/result and set `first_fail_valid`.
  - In the same cycle, advance `idx` and reset the counter.
- Normal end: the compare at `idx`=all-ones moves the state to DONE. `done` pulses and `pass`=(count==0). `op1`/`op2` hold all-ones.
- STOP_ON_FAIL=1: the first mismatch moves the state to DONE after counting, with `done` pulse and `pass`=0. `op1`/`op2` hold the failing vector.
- `abort` in RUN behaviour:
  - next state IDLE, no `done`, `pass`=0;
  - count and first-fail fields are frozen;
  - `op1`/`op2` hold.
- `abort` has priority over a compare in the same cycle; that vector is not counted.
- `start` while RUN is ignored. `start` and `abort` together in IDLE/DONE: `start` wins.
- `mismatch_count` cannot exceed 2^(2*WIDTH), so it never wraps.

## Timing
- `start` sampled at edge N: `busy`=1 and `op1`=`op2`=0 from edge N+1.
- Each vector occupies SETTLE+1 cycles. The result is sampled at the edge ending the vector's last cycle, and operands update on that same edge.
- Full sweep: `done` is high for the cycle after edge N + 2^(2*WIDTH)*(SETTLE+1). `busy` falls on the same edge `done` rises.
- The count and first-fail fields update on the compare edge. They are visible from the next cycle.
- Reset mid-sweep: the next edge with `rst_n`=0 forces reset values. No `done` pulse.

## Test plan
- Ideal adder model, WIDTH=8, SETTLE=0, `start`: `done` after 65536 cycles, `pass`=1, count 0, `first_fail_valid`=0, `op1`=`op2`=0xFF.
- Model wrong only at op1=0x03, op2=0x05 (result 0x09): count 1, first fail 0x03/0x05/0x09, `pass`=0.
- Result bit0 stuck-at-0, SETTLE=2: count 32768, first fail 0x00/0x01/0x00, `done` after 196608 cycles.
- Same fault with STOP_ON_FAIL=1: `done` at the second vector (cycle 2 for SETTLE=0), count 1, `op2` holds 0x01.
- `abort` at cycle 100 with an ideal model: `busy` low next cycle, no `done`, `pass`=0. A restarted `start` clears the count and runs the full sweep.
- `rst_n` low at cycle 500, then `start`: all outputs zero during reset. The fresh sweep completes with correct count.
